// File: rtl/byte_dispatch_ctrl_if.sv
// rtl/byte_dispatch_ctrl_if.sv - upstream byte stream and demux-side signals of the dispatch controller
interface byte_dispatch_ctrl_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [3:0] lane_ready;
   logic [7:0] demux_a;
   logic       s1;
   logic       s0;
   logic [3:0] lane_load;

   // Environment side: produces bytes and lane readiness, observes the demux drive
   modport master (
      output in_valid, in_data, lane_ready,
      input  in_ready, demux_a, s1, s0, lane_load
   );

   // Controller side
   modport slave (
      input  in_valid, in_data, lane_ready,
      output in_ready, demux_a, s1, s0, lane_load
   );
endinterface

// File: rtl/byte_dispatch_ctrl.sv
// rtl/byte_dispatch_ctrl.sv - holds one byte and dispatches it to a demux lane (round-robin or fixed)
module byte_dispatch_ctrl #(
   parameter int STALL_LIMIT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   byte_dispatch_ctrl_if.slave bus,
   input  logic             mode,
   input  logic [1:0]       lane_sel,
   output logic             skip,
   output logic [CNT_W-1:0] xfer_count
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   localparam int SW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
   localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT - 1);

   logic [0:0]       state_q,     state_d;
   logic [7:0]       hold_data_q, hold_data_d;
   logic [1:0]       tgt_q,       tgt_d;
   logic [1:0]       ptr_q,       ptr_d;
   logic             mode_q,      mode_d;
   logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
   logic             skip_q,      skip_d;
   logic [CNT_W-1:0] xfer_q,      xfer_d;

   logic             deliver;

   // The held byte can only leave when its target lane is ready; a reset cycle never delivers
   assign deliver = (state_q == WAIT) && bus.lane_ready[tgt_q] && !rst;

   // Next-state logic: accept in IDLE, deliver or stall/skip in WAIT
   always_comb begin
      state_d     = state_q;
      hold_data_d = hold_data_q;
      tgt_d       = tgt_q;
      ptr_d       = ptr_q;
      mode_d      = mode_q;
      stall_cnt_d = stall_cnt_q;
      skip_d      = 1'b0;
      xfer_d      = xfer_q;
      if (state_q == IDLE) begin
         if (bus.in_valid) begin
            hold_data_d = bus.in_data;
            tgt_d       = mode ? lane_sel : ptr_q;
            mode_d      = mode;
            stall_cnt_d = '0;
            state_d     = WAIT;
         end
      end else begin
         if (bus.lane_ready[tgt_q]) begin
            state_d = IDLE;
            xfer_d  = xfer_q + CNT_W'(1);
            if (!mode_q) begin
               ptr_d = tgt_q + 2'd1;
            end
         end else if (!mode_q) begin
            // Round-robin: give up on a stuck lane and retarget the same byte
            if (stall_cnt_q == STALL_MAX) begin
               tgt_d       = tgt_q + 2'd1;
               stall_cnt_d = '0;
               skip_d      = 1'b1;
            end else begin
               stall_cnt_d = stall_cnt_q + SW'(1);
            end
         end else if (stall_cnt_q != STALL_MAX) begin
            // Fixed lane: count saturates, the byte waits indefinitely
            stall_cnt_d = stall_cnt_q + SW'(1);
         end
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_data_q <= '0;
         tgt_q       <= '0;
         ptr_q       <= '0;
         mode_q      <= 1'b0;
         stall_cnt_q <= '0;
         skip_q      <= 1'b0;
         xfer_q      <= '0;
      end else begin
         state_q     <= state_d;
         hold_data_q <= hold_data_d;
         tgt_q       <= tgt_d;
         ptr_q       <= ptr_d;
         mode_q      <= mode_d;
         stall_cnt_q <= stall_cnt_d;
         skip_q      <= skip_d;
         xfer_q      <= xfer_d;
      end
   end

   // One-hot load strobe into the target lane register during the delivery cycle
   always_comb begin
      bus.lane_load = 4'b0000;
      if (deliver) begin
         bus.lane_load = 4'b0001 << tgt_q;
      end
   end

   assign bus.in_ready = (state_q == IDLE);
   assign bus.demux_a  = (state_q == WAIT) ? hold_data_q : 8'h00;
   assign bus.s1       = (state_q == WAIT) ? tgt_q[1] : 1'b0;
   assign bus.s0       = (state_q == WAIT) ? tgt_q[0] : 1'b0;
   assign skip         = skip_q;
   assign xfer_count   = xfer_q;

endmodule
